snake_game_ctrl: RTL and testbench

- Top-level sequencer for snake_calculate: issues start, step and grow pulses, latches player keys, and paces steps with a programmable timer.
- After every step, checks the new head against the walls, the food cell and every body segment.
- Sits between input/food logic and snake_calculate. Drives game_over, win and score to the display path.

---
 rtl/snake_game_ctrl_pkg.sv | 16 +
 rtl/snake_game_ctrl_if.sv | 10 +
 rtl/snake_game_ctrl_step_timer.sv | 19 +
 rtl/snake_game_ctrl.sv | 102 ++++++++++
 tb/tb_snake_game_ctrl.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/snake_game_ctrl_pkg.sv
// snake_game_ctrl_pkg: shared states, key codes, coordinate widths and segment field helpers
package snake_pkg;
  localparam int COORD_W = 8;
  localparam int SEG_W = 16;
  typedef enum logic [2:0] {IDLE, INIT, RUN, STEP, SETTLE, CHECK, OVER, PAUSE} state_e;
  localparam logic [1:0] KEY_W = 2'b00;
  localparam logic [1:0] KEY_A = 2'b01;
  localparam logic [1:0] KEY_S = 2'b11;
  localparam logic [1:0] KEY_D = 2'b10;
  function automatic logic [COORD_W-1:0] seg_x(input logic [SEG_W-1:0] s);
    return s[COORD_W-1:0];
  endfunction
  function automatic logic [COORD_W-1:0] seg_y(input logic [SEG_W-1:0] s);
    return s[SEG_W-1:COORD_W];
  endfunction
endpackage

// File: rtl/snake_game_ctrl_if.sv
// snake_game_ctrl_if: control and snake-state link between the game sequencer and snake_calculate
interface snake_game_ctrl_if #(parameter int SNAKE_SIZE = 1600);
  logic start, step, grow, food_req;
  logic [1:0] key_out;
  logic [15:0] lengh;
  logic [SNAKE_SIZE-1:0] snake_xy;
  logic [7:0] food_x, food_y;
  modport master(output start, step, grow, key_out, food_req, input lengh, snake_xy, food_x, food_y);
  modport slave(input start, step, grow, key_out, food_req, output lengh, snake_xy, food_x, food_y);
endinterface

// File: rtl/snake_game_ctrl_step_timer.sv
// snake_step_timer: step pacing counter with enable, clear, freeze and terminal-count output
module snake_step_timer #(
  parameter int PERIOD = 2500000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  input  logic i_frz,
  output logic o_tc
);
  localparam int CW = PERIOD > 1 ? $clog2(PERIOD) : 1;
  logic [CW-1:0] r_cnt;
  assign o_tc = i_en && !i_frz && r_cnt == CW'(PERIOD - 1);
  always_ff @(posedge clk) begin
    if (rst || i_clr || o_tc) r_cnt <= '0;
    else if (i_en && !i_frz) r_cnt <= r_cnt + 1'b1;
  end
endmodule

// File: rtl/snake_game_ctrl.sv
// snake_game_ctrl: snake game sequencer with wall/food/body checks; SNAKE_PAUSE_EN adds btn_pause and PAUSE
module snake_game_ctrl
  import snake_pkg::*;
#(
  parameter int SIZE_X      = 10,
  parameter int SIZE_Y      = 10,
  parameter int STEP_PERIOD = 2500000,
  parameter int MAX_LEN     = SIZE_X * SIZE_Y,
  parameter int SNAKE_SIZE  = 8 * MAX_LEN * 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_start,
  input  logic        key_valid,
  input  logic [1:0]  key,
`ifdef SNAKE_PAUSE_EN
  input  logic        btn_pause,
`endif
  output logic [15:0] score,
  output logic        game_over,
  output logic        win,
  snake_game_ctrl_if.master bus
);
  localparam int IW = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
  state_e r_state, w_nxt;
  logic r_sub, r_pend, r_win;
  logic [IW-1:0] r_idx;
  logic [15:0] r_score, w_lim;
  logic [1:0] r_key;
  logic [SEG_W-1:0] w_segs [MAX_LEN];
  logic [SEG_W-1:0] w_head;
  logic w_pause, w_tc, w_wall, w_eat, w_hit, w_end, w_win, w_key_ok;
  genvar g;
  for (g = 0; g < MAX_LEN; g++) begin : g_seg
    assign w_segs[g] = bus.snake_xy[g*SEG_W +: SEG_W];
  end
`ifdef SNAKE_PAUSE_EN
  assign w_pause = btn_pause;
`else
  assign w_pause = 1'b0;
`endif
  snake_step_timer #(.PERIOD(STEP_PERIOD)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .i_en (r_state == RUN || r_state == PAUSE),
    .i_clr(r_state == INIT),
    .i_frz(r_state == PAUSE || w_pause),
    .o_tc (w_tc)
  );
  assign w_head = w_segs[0];
  assign w_lim = bus.lengh > 16'(MAX_LEN) ? 16'(MAX_LEN) : bus.lengh;
  // underflowed coordinates wrap to 255 and so land outside the field
  assign w_wall = 32'(seg_x(w_head)) >= SIZE_X || 32'(seg_y(w_head)) >= SIZE_Y;
  assign w_eat = r_state == CHECK && r_idx == '0 && !w_wall && w_head == {bus.food_y, bus.food_x};
  assign w_hit = r_state == CHECK && (r_idx == '0 ? w_wall : w_segs[r_idx] == w_head);
  assign w_end = r_state == CHECK && 16'(r_idx) + 16'd1 >= w_lim;
  assign w_win = w_end && !w_hit && bus.lengh >= 16'(MAX_LEN);
  assign w_key_ok = r_state == RUN || r_state == STEP || r_state == SETTLE || r_state == CHECK;
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:    w_nxt = btn_start ? INIT : IDLE;
      INIT:    w_nxt = RUN;
      RUN:     w_nxt = w_pause ? PAUSE : w_tc ? STEP : RUN;
      PAUSE:   w_nxt = w_pause ? RUN : PAUSE;
      STEP:    w_nxt = SETTLE;
      SETTLE:  w_nxt = r_sub ? CHECK : SETTLE;
      CHECK:   w_nxt = w_hit || w_win ? OVER : w_end ? RUN : CHECK;
      OVER:    w_nxt = btn_start ? INIT : OVER;
      default: w_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_nxt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sub   <= 1'b0;
      r_idx   <= '0;
      r_pend  <= 1'b0;
      r_win   <= 1'b0;
      r_score <= '0;
      r_key   <= KEY_S;
    end else begin
      r_sub   <= r_state == SETTLE && !r_sub;
      r_idx   <= r_state == CHECK && w_nxt == CHECK ? r_idx + 1'b1 : '0;
      r_pend  <= w_nxt == INIT || r_state == STEP ? 1'b0 : w_eat ? 1'b1 : r_pend;
      r_win   <= w_nxt == INIT ? 1'b0 : w_win ? 1'b1 : r_win;
      r_score <= w_nxt == INIT ? '0 : w_eat && r_score != 16'hFFFF ? r_score + 16'd1 : r_score;
      r_key   <= w_nxt == INIT ? KEY_S : key_valid && w_key_ok ? key : r_key;
    end
  end
  assign bus.start    = r_state == INIT;
  assign bus.step     = r_state == STEP;
  assign bus.grow     = r_state == STEP && r_pend;
  assign bus.food_req = w_eat;
  assign bus.key_out  = r_key;
  assign score        = r_score;
  assign game_over    = r_state == OVER;
  assign win          = r_win;
endmodule

// File: tb/tb_snake_game_ctrl.sv
// tb_snake_game_ctrl: directed checks of start, pacing, food, wall, body, win, reset and pause
module tb_snake_game_ctrl;
  logic clk = 1'b0, rst = 1'b1, btn_start = 1'b0, key_valid = 1'b0;
  logic [1:0] key = 2'b00;
  logic [15:0] score;
  logic game_over, win;
  int n_cmp = 0, n_bad = 0;
`ifdef SNAKE_PAUSE_EN
  logic btn_pause = 1'b0;
`endif
  snake_game_ctrl_if #(.SNAKE_SIZE(1600)) bus();
  snake_game_ctrl #(
    .SIZE_X(10), .SIZE_Y(10), .STEP_PERIOD(8), .MAX_LEN(100), .SNAKE_SIZE(1600)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_start(btn_start),
    .key_valid(key_valid),
    .key      (key),
`ifdef SNAKE_PAUSE_EN
    .btn_pause(btn_pause),
`endif
    .score    (score),
    .game_over(game_over),
    .win      (win),
    .bus      (bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic seg(input int i, input int x, input int y);
    bus.snake_xy[i*16 +: 16] = {8'(y), 8'(x)};
  endtask
  task automatic wait_step(output int n);
    n = 0;
    while (bus.step !== 1'b1 && n < 200) begin
      tick;
      n++;
    end
  endtask
  task automatic wait_over(output int n);
    n = 0;
    while (game_over !== 1'b1 && n < 300) begin
      tick;
      n++;
    end
  endtask
  task automatic start_game;
    btn_start = 1'b1;
    tick;
    chk("init_start", 32'(bus.start), 1);
    chk("init_score", 32'(score), 0);
    chk("init_key", 32'(bus.key_out), 3);
    btn_start = 1'b0;
    tick;
  endtask
  task automatic full_field;
    for (int i = 0; i < 100; i++) seg(i, i % 10, i / 10);
    bus.lengh = 16'd100;
  endtask
  int n;
  initial begin
    bus.lengh = 16'd3;
    bus.snake_xy = '0;
    seg(0, 5, 5); seg(1, 4, 5); seg(2, 3, 5);
    bus.food_x = 8'd0;
    bus.food_y = 8'd0;
    tick; tick;
    rst = 1'b0;
    tick;
    chk("rst_start", 32'(bus.start), 0);
    chk("rst_step", 32'(bus.step), 0);
    chk("rst_over", 32'(game_over), 0);
    chk("rst_win", 32'(win), 0);
    chk("rst_score", 32'(score), 0);
    chk("rst_key", 32'(bus.key_out), 3);
    key_valid = 1'b1; key = 2'b00;
    tick;
    chk("idle_key_ignored", 32'(bus.key_out), 3);
    key_valid = 1'b0;
    start_game;
    chk("start_one_pulse", 32'(bus.start), 0);
    wait_step(n);
    chk("first_step_delay", 32'(n), 8);
    chk("first_grow", 32'(bus.grow), 0);
    seg(0, 3, 4); seg(1, 2, 4); seg(2, 1, 4);
    bus.food_x = 8'd3; bus.food_y = 8'd4;
    key_valid = 1'b1; key = 2'b01;
    tick;
    key_valid = 1'b0;
    chk("key_latched", 32'(bus.key_out), 1);
    tick; tick;
    chk("food_req", 32'(bus.food_req), 1);
    chk("score_before", 32'(score), 0);
    tick;
    chk("food_req_pulse", 32'(bus.food_req), 0);
    chk("score_eat", 32'(score), 1);
    wait_step(n);
    chk("second_step", 32'(n < 200), 1);
    chk("grow_after_eat", 32'(bus.grow), 1);
    seg(0, 255, 4);
    bus.food_x = 8'd255; bus.food_y = 8'd4;
    tick; tick; tick;
    chk("wall_no_food", 32'(bus.food_req), 0);
    tick;
    chk("wall_over", 32'(game_over), 1);
    chk("wall_score", 32'(score), 1);
    chk("wall_win", 32'(win), 0);
    start_game;
    wait_step(n);
    chk("body_step_delay", 32'(n), 8);
    bus.lengh = 16'd5;
    seg(0, 5, 5); seg(1, 4, 5); seg(2, 4, 6); seg(3, 5, 5); seg(4, 6, 5);
    bus.food_x = 8'd0; bus.food_y = 8'd0;
    tick; tick; tick;
    wait_over(n);
    chk("body_cycles", 32'(n), 4);
    chk("body_win", 32'(win), 0);
    start_game;
    wait_step(n);
    full_field;
    bus.food_x = 8'd9; bus.food_y = 8'd9;
    key_valid = 1'b1; key = 2'b00;
    tick;
    key_valid = 1'b0;
    chk("key_w", 32'(bus.key_out), 0);
    tick; tick;
    wait_over(n);
    chk("win_cycles", 32'(n), 100);
    chk("win_flag", 32'(win), 1);
    chk("win_score", 32'(score), 0);
    btn_start = 1'b1;
    tick;
    chk("restart_start", 32'(bus.start), 1);
    chk("restart_key", 32'(bus.key_out), 3);
    chk("restart_win", 32'(win), 0);
    btn_start = 1'b0;
    tick;
    bus.lengh = 16'd3;
    wait_step(n);
    full_field;
    bus.food_x = 8'd0; bus.food_y = 8'd0;
    tick; tick; tick;
    chk("mid_food_req", 32'(bus.food_req), 1);
    tick;
    chk("mid_score", 32'(score), 1);
    tick; tick; tick; tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("mid_rst_over", 32'(game_over), 0);
    chk("mid_rst_score", 32'(score), 0);
    chk("mid_rst_step", 32'(bus.step), 0);
    chk("mid_rst_grow", 32'(bus.grow), 0);
    chk("mid_rst_food_req", 32'(bus.food_req), 0);
    chk("mid_rst_key", 32'(bus.key_out), 3);
    tick;
    chk("idle_holds", 32'(bus.start), 0);
`ifdef SNAKE_PAUSE_EN
    bus.lengh = 16'd3;
    seg(0, 5, 5); seg(1, 4, 5); seg(2, 3, 5);
    start_game;
    tick; tick; tick;
    btn_pause = 1'b1;
    tick;
    btn_pause = 1'b0;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      tick;
      n += int'(bus.step);
    end
    chk("pause_no_step", 32'(n), 0);
    btn_pause = 1'b1;
    tick;
    btn_pause = 1'b0;
    wait_step(n);
    chk("resume_delay", 32'(n), 5);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
